watch_time_counter: RTL
=======================

# watch_time_counter

Time-of-day keeper directly downstream of `watch_fsm`. It consumes `run_time`, `inc_m`, `dec_m`, `inc_h` and `dec_h`, and holds hours, minutes and seconds as BCD digits for the display driver. A parameterised prescaler divides the system clock to 1 Hz. Hour and minute adjustment is edge-triggered, so one button press gives exactly one step.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 32768: clk cycles per second (the 32.768 kHz watch crystal).
- `PRESC_W`, default 15: prescaler width, ≥ clog2(TICKS_PER_SEC).

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-high.
- `run_time` in 1: 1 = advance time each second; 0 = set mode (adjust enabled).
- `inc_m` in 1: minute increment request (level from FSM).
- `dec_m` in 1: minute decrement request.
- `inc_h` in 1: hour increment request.
- `dec_h` in 1: hour decrement request.
- `h_tens` out 2: hours tens digit, 0–2.
- `h_ones` out 4: hours ones digit, 0–9.
- `m_tens` out 3: minutes tens digit, 0–5.
- `m_ones` out 4: minutes ones digit, 0–9.
- `s_tens` out 3: seconds tens digit, 0–5.
- `s_ones` out 4: seconds ones digit, 0–9.
- `sec_pulse` out 1: one-cycle strobe on each seconds advance.

## Operation
- **Reset** (async, any time, including mid-adjust): all digits 0 (00:00:00), prescaler 0, `sec_pulse` 0, edge-detect history registers 0.
- **Prescaler:** counts 0..TICKS_PER_SEC−1 while `run_time`=1. At the terminal count it returns to 0 and advances seconds.
- **Advance chain:**
  - Seconds 59 → 00 with carry to minutes.
  - Minutes 59 → 00 with carry to hours.
  - Hours 23 → 00; no day carry.
  - All carries resolve in the same edge (23:59:59 → 00:00:00 in one cycle).
- **`run_time`=0:**
  - Prescaler held at 0.
  - Seconds forced to 00.
  - `sec_pulse` held 0.
  - Minutes and hours hold except for adjusts.
- **Adjust:** a step fires when a strobe is 1 this cycle and its history register was 0 (rising edge). Steps are only honoured while `run_time`=0; while `run_time`=1, edges are ignored but history still updates.
  - `inc_m`/`dec_m`: minutes ±1, wrapping 59↔00. No carry into hours.
  - `inc_h`/`dec_h`: hours ±1, wrapping 23↔00.
- **Simultaneous events:**
  - inc and dec edges on the same field in the same cycle: no change.
  - Minute and hour edges in the same cycle: both applied.
- **BCD rules:**
  - Ones digit wraps 9→0 with a tens carry.
  - Decrement from x0 borrows: 10 → 09.
  - Hours special cases: 23→00 on increment, 00→23 on decrement, 19→20, 20→19.
  - Digits never hold illegal values.

## Timing
- Step latency: a strobe first sampled high at edge N updates the digit at edge N, so the new value is visible after N.
- Holding a strobe high gives exactly one step. Releasing it for ≥1 cycle re-arms.
- First seconds advance comes TICKS_PER_SEC edges after `run_time` is sampled 1 with the prescaler at 0.
- Advance period is exactly TICKS_PER_SEC cycles.
- `sec_pulse` is high for the one cycle after the advancing edge.
- `run_time` falling mid-second: the partial second is discarded and seconds are cleared at that edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **`watch_pkg`** holds the limits (SEC_MAX=59, MIN_MAX=59, HR_MAX=23), the BCD digit widths, and the default TICKS_PER_SEC. The same package serves `watch_fsm` and the stopwatch counter.
- **Sub-module `watch_bcd_pair`** is a two-digit BCD up/down counter with:
  - Inputs: parameter max value, `inc`, `dec`, `clr`.
  - Outputs: `carry_out` on wrap-up.
  - Instantiated three times: seconds (inc only), minutes, hours.
- **Top level:** prescaler, edge-detect registers, carry gating and run/set muxing.

## Test plan
Bench uses TICKS_PER_SEC=4.
- **Reset/advance:** assert reset mid-cycle with `run_time`=1 → outputs 00:00:00 immediately. After release, `sec_pulse` every 4 cycles and s_ones reaches 3 after 12 cycles.
- **Full wrap:** preload 23:59:59 via adjusts plus run → one advance gives 00:00:00 in a single edge.
- **Hold strobe:** `run_time`=0, hold `inc_h` for 10 cycles → hours +1 only. Release, pulse again → +1 again. Repeat 5 times from 18 → 23.
- **Borrow/wrap:**
  - `dec_m` at 00 → 59.
  - `dec_h` at 00 → 23.
  - `dec_h` at 20 → 19.
  - `inc_m` at 59 → 00 with hours unchanged.
- **Simultaneous/ignored:**
  - `inc_m`+`dec_m` same edge → no change.
  - `inc_m`+`inc_h` same edge → both +1.
  - `inc_m` edge with `run_time`=1 → ignored.
- **Set-mode entry:** `run_time` 1→0 at s=37 with prescaler at 2 → seconds 00 at that edge and `sec_pulse` silent. Back to 1 → first pulse exactly 4 cycles later.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared limits, digit widths and step encoding for the watch counters.
package watch_pkg;

   localparam int SEC_MAX           = 59;
   localparam int MIN_MAX           = 59;
   localparam int HR_MAX            = 23;
   localparam int ONES_W            = 4;
   localparam int SEC_TENS_W        = 3;
   localparam int MIN_TENS_W        = 3;
   localparam int HR_TENS_W         = 2;
   localparam int TICKS_PER_SEC_DEF = 32768;

   typedef enum logic [1:0] {
      STEP_HOLD = 2'b00,
      STEP_UP   = 2'b01,
      STEP_DOWN = 2'b10
   } step_e;

   // Opposing requests on the same field cancel out.
   function automatic step_e step_op(input logic inc, input logic dec);
      step_e op;
      case ({inc, dec})
         2'b10:   op = STEP_UP;
         2'b01:   op = STEP_DOWN;
         default: op = STEP_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/watch_bcd_pair.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX_VAL.
module watch_bcd_pair
   import watch_pkg::*;
#(
   parameter int MAX_VAL = 59,
   parameter int TENS_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              dec,
   input  logic              clr,
   output logic [TENS_W-1:0] tens,
   output logic [ONES_W-1:0] ones,
   output logic              carry_out
);

   localparam logic [TENS_W-1:0] MAX_T  = TENS_W'(MAX_VAL / 10);
   localparam logic [ONES_W-1:0] MAX_O  = ONES_W'(MAX_VAL % 10);
   localparam logic [TENS_W-1:0] ZERO_T = TENS_W'(0);
   localparam logic [TENS_W-1:0] ONE_T  = TENS_W'(1);

   logic [TENS_W-1:0] tens_q, tens_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic              at_max_s, at_zero_s;
   step_e             op_s;

   // Next digit values; carry_out is combinational so chained pairs settle on one edge.
   always_comb begin
      op_s      = step_op(inc, dec);
      at_max_s  = (tens_q == MAX_T) && (ones_q == MAX_O);
      at_zero_s = (tens_q == ZERO_T) && (ones_q == 4'd0);
      tens_d    = tens_q;
      ones_d    = ones_q;
      carry_out = 1'b0;
      if (clr) begin
         tens_d = ZERO_T;
         ones_d = 4'd0;
      end else begin
         case (op_s)
            STEP_UP: begin
               if (at_max_s) begin
                  tens_d    = ZERO_T;
                  ones_d    = 4'd0;
                  carry_out = 1'b1;
               end else if (ones_q == 4'd9) begin
                  tens_d = tens_q + ONE_T;
                  ones_d = 4'd0;
               end else begin
                  ones_d = ones_q + 4'd1;
               end
            end
            STEP_DOWN: begin
               if (at_zero_s) begin
                  tens_d = MAX_T;
                  ones_d = MAX_O;
               end else if (ones_q == 4'd0) begin
                  tens_d = tens_q - ONE_T;
                  ones_d = 4'd9;
               end else begin
                  ones_d = ones_q - 4'd1;
               end
            end
            default: begin
               tens_d = tens_q;
               ones_d = ones_q;
            end
         endcase
      end
   end

   // Digit registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tens_q <= ZERO_T;
         ones_q <= 4'd0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/watch_time_counter.sv
// Time-of-day keeper: 1 Hz prescaler, HH:MM:SS BCD chain and edge-triggered set adjusts.
module watch_time_counter
   import watch_pkg::*;
#(
   parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
   parameter int PRESC_W       = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run_time,
   input  logic                  inc_m,
   input  logic                  dec_m,
   input  logic                  inc_h,
   input  logic                  dec_h,
   output logic [HR_TENS_W-1:0]  h_tens,
   output logic [ONES_W-1:0]     h_ones,
   output logic [MIN_TENS_W-1:0] m_tens,
   output logic [ONES_W-1:0]     m_ones,
   output logic [SEC_TENS_W-1:0] s_tens,
   output logic [ONES_W-1:0]     s_ones,
   output logic                  sec_pulse
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
   localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [3:0]         hist_q, strb_s, adj_s;
   logic               sec_pulse_q, tick_s;
   logic               sec_carry_s, min_carry_s, hr_carry_unused_s;
   logic               min_inc_s, hr_inc_s;

   // Prescaler, strobe edge detect and run/set gating; adj_s is {inc_m, dec_m, inc_h, dec_h}.
   always_comb begin
      tick_s  = run_time && (presc_q == PRESC_LAST);
      presc_d = presc_q + PRESC_ONE;
      if (!run_time || tick_s) begin
         presc_d = PRESC_ZERO;
      end else begin
         presc_d = presc_q + PRESC_ONE;
      end
      strb_s    = {inc_m, dec_m, inc_h, dec_h};
      adj_s     = run_time ? 4'b0000 : (strb_s & ~hist_q);
      min_inc_s = (run_time & sec_carry_s) | adj_s[3];
      hr_inc_s  = (run_time & min_carry_s) | adj_s[1];
   end

   // History keeps tracking strobes in run mode so a held button cannot step on entry to set mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q     <= PRESC_ZERO;
         hist_q      <= 4'b0000;
         sec_pulse_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         hist_q      <= strb_s;
         sec_pulse_q <= tick_s;
      end
   end

   watch_bcd_pair #(.MAX_VAL(SEC_MAX), .TENS_W(SEC_TENS_W)) u_sec (
      .clk       (clk),
      .reset     (reset),
      .inc       (tick_s),
      .dec       (1'b0),
      .clr       (~run_time),
      .tens      (s_tens),
      .ones      (s_ones),
      .carry_out (sec_carry_s)
   );

   watch_bcd_pair #(.MAX_VAL(MIN_MAX), .TENS_W(MIN_TENS_W)) u_min (
      .clk       (clk),
      .reset     (reset),
      .inc       (min_inc_s),
      .dec       (adj_s[2]),
      .clr       (1'b0),
      .tens      (m_tens),
      .ones      (m_ones),
      .carry_out (min_carry_s)
   );

   watch_bcd_pair #(.MAX_VAL(HR_MAX), .TENS_W(HR_TENS_W)) u_hr (
      .clk       (clk),
      .reset     (reset),
      .inc       (hr_inc_s),
      .dec       (adj_s[0]),
      .clr       (1'b0),
      .tens      (h_tens),
      .ones      (h_ones),
      .carry_out (hr_carry_unused_s)
   );

   assign sec_pulse = sec_pulse_q;

endmodule
